hwpe_stream_rr_arbiter: RTL
===========================

# hwpe_stream_rr_arbiter

Round-robin burst arbiter that shares one HWPE-Stream sink between `NB_IN` requesting HWPE-Stream sources. Typical use: merging several producer streams into a single `hwpe_stream_fifo` / passthrough FIFO input. Once an input is granted, it holds the grant for up to `BURST_LEN` handshakes. This keeps short packets contiguous while guaranteeing fairness. Data is forwarded combinationally while granted; arbitration itself is registered.

## Interface
- `NB_IN`, 4: number of input streams (≥2).
- `DATA_WIDTH`, 32: stream data width; strb width is `DATA_WIDTH/8`.
- `BURST_LEN`, 4: maximum handshakes per grant (≥1).
- `ID_WIDTH`, `$clog2(NB_IN)`: width of the grant index (derived, not overridden).

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` input 1: clock.
- `rst_i` input 1: asynchronous active-high reset.
- `clear_i` input 1: synchronous clear, same effect as reset.
- `enable_i` input 1: permits new grants when high.
- `push_i[NB_IN]` sink intf `DATA_WIDTH`: requesting streams.
- `pop_o` source intf `DATA_WIDTH`: merged output stream.
- `grant_o` output `ID_WIDTH`: index of the currently/last granted input.
- `busy_o` output 1: high while in GRANT.
- `starve_cnt_o` output 16: only with the macro; see Configuration.

## Operation
- FSM states: IDLE and GRANT.
  - Registers: `state`, `grant_q` (`ID_WIDTH`), `rr_ptr_q` (`ID_WIDTH`), `beat_q` (`$clog2(BURST_LEN+1)` bits).
- Reset/clear values: state=IDLE, `grant_q`=0, `rr_ptr_q`=0, `beat_q`=0.
  - Outputs after reset: `pop_o.valid`=0, all `push_i[i].ready`=0, `grant_o`=0, `busy_o`=0.
- IDLE:
  - `pop_o.valid`=0, all `push_i.ready`=0.
  - If `enable_i` and any `push_i[i].valid`: select the first valid index scanning `rr_ptr_q`, `rr_ptr_q+1`, … modulo `NB_IN`.
  - On selection: `grant_q`←index, `beat_q`←0, next state GRANT.
- GRANT: with `g = grant_q`:
  - `pop_o.valid/data/strb` = `push_i[g].valid/data/strb`.
  - `push_i[g].ready` = `pop_o.ready`; all other `push_i.ready`=0.
- Handshake in GRANT: `push_i[g].valid & pop_o.ready`; `beat_q` increments on each handshake.
- Release from GRANT to IDLE, with `rr_ptr_q` ← (`g`+1) mod `NB_IN`, when either:
  - a handshake occurs with `beat_q == BURST_LEN-1`, or
  - `push_i[g].valid`=0 (requester went quiet).
- `enable_i` only gates the IDLE→GRANT transition. Deasserting it in GRANT does not cut the burst short.
- Non-granted inputs never see `ready`=1. Their valid/data must stay stable (HWPE-Stream rule); the arbiter does not check this.
- Simultaneous events:
  - `clear_i` has priority over all transitions.
  - `clear_i` in the same cycle as a handshake: the beat is transferred that cycle; state is IDLE next cycle.
- Modulo wrap: `rr_ptr_q` wraps from `NB_IN-1` to 0. For non-power-of-2 `NB_IN`, indices ≥`NB_IN` are never produced.

## Timing
- Arbitration latency: 1 cycle from the IDLE cycle where a valid is seen to the first cycle forwarding in GRANT.
- GRANT path is combinational from `push_i` to `pop_o` and from `pop_o.ready` to `push_i.ready`. No register is added.
- Every release costs one IDLE bubble cycle.
  - Peak throughput with always-valid inputs and `pop_o.ready`=1 is `BURST_LEN/(BURST_LEN+1)` beats per cycle.
- `grant_o` is driven from `grant_q` (registered) and holds its value in IDLE. `busy_o` = (state==GRANT).
- Reset mid-burst: outputs drop to their reset values asynchronously. A partially transferred burst is not resumed.

## Configuration
- Macro: `HWPE_STREAM_RR_ARBITER_STARVE_CNT_EN`.
- Defined:
  - Adds port `starve_cnt_o[15:0]` and a 16-bit counter.
  - The counter increments each cycle in which some `push_i[i].valid`=1 with i≠`grant_q`, or state==IDLE.
  - It saturates at 16'hFFFF and is cleared by `rst_i`/`clear_i`.
- Undefined: the port and counter are absent; arbitration behaviour is identical.

## Test plan
- Reset then idle: hold `rst_i`=1, then release with all valids 0 → `pop_o.valid`=0, `busy_o`=0, `grant_o`=0 for 10 cycles.
- Single requester: `NB_IN`=4, `BURST_LEN`=4, input 2 presents 8 beats 0x10..0x17, `pop_o.ready`=1.
  - `grant_o`=2.
  - Output sequence 0x10–0x13, then 1 bubble, then 0x14–0x17.
  - Total 10 cycles after the first IDLE.
- Fairness: inputs 0, 1 and 3 always valid → grant order 0, 1, 3, 0, 1, 3…, with exactly 4 beats per grant.
- Early release: input 1 sends 2 beats then drops valid; input 0 is valid → burst ends after 2 beats; next grant is 0 only after scanning from `rr_ptr_q`=2 (3, 0).
- Backpressure: `pop_o.ready` toggled 1,0,1,0 during a grant → `push_i[g].ready` mirrors it exactly; `beat_q` advances only on the ready=1 cycles; data is held stable.
- Clear mid-burst: assert `clear_i` after 2 beats of input 3 → next cycle `busy_o`=0, `grant_o`=0, and the next grant starts scanning at index 0. With the macro: `starve_cnt_o`=0.

Source files
------------

// File: rtl/hwpe_stream_rr_arbiter.sv
// Round-robin burst arbiter merging NB_IN HWPE-Stream sources into one sink.
// Optional starvation counter enabled by defining HWPE_STREAM_RR_ARBITER_STARVE_CNT_EN.
module hwpe_stream_rr_arbiter #(
  parameter  int unsigned NB_IN      = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned ID_WIDTH   = $clog2(NB_IN),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  enable_i,
  input  logic [NB_IN-1:0]                      push_valid_i,
  input  logic [NB_IN-1:0][DATA_WIDTH-1:0]      push_data_i,
  input  logic [NB_IN-1:0][STRB_WIDTH-1:0]      push_strb_i,
  output logic [NB_IN-1:0]                      push_ready_o,
  output logic                                  pop_valid_o,
  output logic [DATA_WIDTH-1:0]                 pop_data_o,
  output logic [STRB_WIDTH-1:0]                 pop_strb_o,
  input  logic                                  pop_ready_i,
  output logic [ID_WIDTH-1:0]                   grant_o,
`ifdef HWPE_STREAM_RR_ARBITER_STARVE_CNT_EN
  output logic [15:0]                           starve_cnt_o,
`endif
  output logic                                  busy_o
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [BEAT_W-1:0]   r_beat;

  logic                w_sel_found;
  logic [ID_WIDTH-1:0] w_sel_idx;
  logic                w_handshake;
  logic                w_release;

  // (base + off) mod NB_IN for base, off < NB_IN; never yields an index >= NB_IN.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NB_IN) sum = sum - NB_IN;
    return ID_WIDTH'(sum);
  endfunction

  // First valid requester scanning from the round-robin pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned k = 0; k < NB_IN; k++) begin
      if (!w_sel_found && push_valid_i[wrap_add(r_rr_ptr, k)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_handshake = (r_state == GRANT) && push_valid_i[r_grant] && pop_ready_i;
  assign w_release   = (r_state == GRANT) &&
                       (!push_valid_i[r_grant] ||
                        (w_handshake && (r_beat == BEAT_W'(BURST_LEN - 1))));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable_i && w_sel_found) w_state_nxt = GRANT;
      GRANT:   if (w_release)               w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else if (clear_i) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else if (r_state == IDLE) begin
      if (enable_i && w_sel_found) begin
        r_grant <= w_sel_idx;
        r_beat  <= '0;
      end
    end else begin
      if (w_handshake) r_beat   <= r_beat + BEAT_W'(1);
      if (w_release)   r_rr_ptr <= wrap_add(r_grant, 1);
    end
  end

  // Outputs: combinational forwarding of the granted input while in GRANT.
  always_comb begin
    pop_valid_o  = 1'b0;
    pop_data_o   = '0;
    pop_strb_o   = '0;
    push_ready_o = '0;
    busy_o       = (r_state == GRANT);
    if (r_state == GRANT) begin
      pop_valid_o           = push_valid_i[r_grant];
      pop_data_o            = push_data_i[r_grant];
      pop_strb_o            = push_strb_i[r_grant];
      push_ready_o[r_grant] = pop_ready_i;
    end
  end

  assign grant_o = r_grant;

`ifdef HWPE_STREAM_RR_ARBITER_STARVE_CNT_EN
  logic [15:0] r_starve_cnt;
  logic        w_starve;

  // Some requester is waiting while another owns the sink, or nobody owns it.
  always_comb begin
    w_starve = (r_state == IDLE);
    for (int unsigned i = 0; i < NB_IN; i++) begin
      if (push_valid_i[i] && (ID_WIDTH'(i) != r_grant)) w_starve = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    r_starve_cnt <= '0;
    else if (clear_i)                             r_starve_cnt <= '0;
    else if (w_starve && (r_starve_cnt != 16'hFFFF)) r_starve_cnt <= r_starve_cnt + 16'd1;
  end

  assign starve_cnt_o = r_starve_cnt;
`endif

endmodule
